// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot/encoded grant and a
// per-ownership hold limit that forces release after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    // Returns {found, index} of the first set request searching upward from ptr.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [7:0]       r_gnt, w_gnt_nxt;
    logic [2:0]       r_gnt_idx, w_idx_nxt;
    logic             r_gnt_valid;
    logic             r_timeout, w_timeout_nxt;
    logic [3:0]       w_pick;

    assign w_pick = rr_pick(bus.req, r_ptr);

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_gnt_idx;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[3]) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = 8'd1 << w_pick[2:0];
                    w_idx_nxt   = w_pick[2:0];
                    w_hold_nxt  = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 8'h00;
                    w_idx_nxt   = 3'd0;
                end
            end
            ST_GRANT: begin
                // A dropped request wins over the hold limit, so timeout stays low then.
                if (!bus.req[r_gnt_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 8'h00;
                    w_idx_nxt   = 3'd0;
                    w_ptr_nxt   = r_gnt_idx + 3'd1;
                end else if (HOLD_EN && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = 8'h00;
                    w_idx_nxt     = 3'd0;
                    w_ptr_nxt     = r_gnt_idx + 3'd1;
                    w_timeout_nxt = 1'b1;
                end else if (r_hold_cnt != CNT_SAT) begin
                    w_hold_nxt = r_hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_hold_nxt = r_hold_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 8'h00;
                w_idx_nxt   = 3'd0;
                w_hold_nxt  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= {CNT_W{1'b0}};
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8: default hold limit plus a MAX_HOLD=4 copy.
module tb_rr_arbiter8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    rr_arbiter8_if bus_a ();
    rr_arbiter8_if bus_b ();

    rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus_a.req = 8'h00;
        bus_b.req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic v, input logic t);
        chk_eq({tag, ".gnt"},   32'(bus_a.gnt),       32'(g));
        chk_eq({tag, ".idx"},   32'(bus_a.gnt_idx),   32'(idx));
        chk_eq({tag, ".valid"}, 32'(bus_a.gnt_valid), 32'(v));
        chk_eq({tag, ".tmo"},   32'(bus_a.timeout),   32'(t));
    endtask

    initial begin
        int exp_seq [4];
        n_cmp = 0;
        n_bad = 0;
        exp_seq = '{0, 7, 0, 7};

        // Test 1: reset while all request
        rst       = 1'b1;
        bus_a.req = 8'hFF;
        bus_b.req = 8'h00;
        step();
        step();
        chk_a("t1_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_a("t1_first", 8'h01, 3'd0, 1'b1, 1'b0);

        // Test 2: single requester holds, then drops
        do_reset();
        bus_a.req = 8'h04;
        step();
        for (int c = 0; c < 5; c++) begin
            chk_a("t2_hold", 8'h04, 3'd2, 1'b1, 1'b0);
            step();
        end
        bus_a.req = 8'h00;
        chk_a("t2_last", 8'h04, 3'd2, 1'b1, 1'b0);
        step();
        chk_a("t2_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Test 3: two requesters alternate with one idle cycle between owners
        do_reset();
        bus_a.req = 8'h81;
        step();
        for (int n = 0; n < 4; n++) begin
            chk_eq("t3_idx", 32'(bus_a.gnt_idx), 32'(exp_seq[n]));
            chk_eq("t3_valid", 32'(bus_a.gnt_valid), 32'd1);
            step();
            chk_eq("t3_idx2", 32'(bus_a.gnt_idx), 32'(exp_seq[n]));
            bus_a.req[exp_seq[n]] = 1'b0;
            step();
            chk_eq("t3_gap", 32'(bus_a.gnt), 32'h0);
            bus_a.req[exp_seq[n]] = 1'b1;
            step();
        end

        // Test 4: MAX_HOLD=4 forced release, periodic regrant
        do_reset();
        bus_b.req = 8'h08;
        step();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk_eq("t4_gnt", 32'(bus_b.gnt), 32'h08);
                chk_eq("t4_idx", 32'(bus_b.gnt_idx), 32'd3);
                chk_eq("t4_tmo0", 32'(bus_b.timeout), 32'd0);
                step();
            end
            chk_eq("t4_relgnt", 32'(bus_b.gnt), 32'h00);
            chk_eq("t4_tmo1", 32'(bus_b.timeout), 32'd1);
            step();
        end
        // Drop coinciding with the hold limit: normal release, no timeout
        for (int c = 0; c < 4; c++) begin
            chk_eq("t4_gnt3", 32'(bus_b.gnt), 32'h08);
            if (c == 3) bus_b.req = 8'h00;
            step();
        end
        chk_eq("t4_dropgnt", 32'(bus_b.gnt), 32'h00);
        chk_eq("t4_droptmo", 32'(bus_b.timeout), 32'd0);
        step();
        chk_eq("t4_idle", 32'(bus_b.gnt_valid), 32'd0);

        // Test 5: pointer wraps from 7 to 0
        do_reset();
        bus_a.req = 8'h80;
        step();
        chk_a("t5_own7", 8'h80, 3'd7, 1'b1, 1'b0);
        bus_a.req = 8'h41;
        step();
        chk_a("t5_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_a("t5_wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        bus_a.req = 8'h40;
        step();
        step();
        chk_a("t5_then6", 8'h40, 3'd6, 1'b1, 1'b0);

        // Test 6: asynchronous reset during a grant restores ptr to 0
        do_reset();
        bus_a.req = 8'h01;
        step();
        bus_a.req = 8'h00;
        step();
        bus_a.req = 8'h20;
        step();
        step();
        chk_a("t6_own5", 8'h20, 3'd5, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_a("t6_async", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst       = 1'b0;
        bus_a.req = 8'h21;
        step();
        chk_a("t6_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
